// File: rtl/mult8_sched_pkg.sv
// mult8_sched_pkg: shared state encoding, default width and requester ids.
// Rev 1.0
`default_nettype none
package mult8_sched_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/mult8_sched_shift_add_dp.sv
// shift_add_dp: operand, accumulator and counter registers for the shift-add multiply.
// Rev 1.0
`default_nettype none
module shift_add_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               sig,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  output logic               last_step,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] addend;

  // product is the accumulator value after the current step completes
  assign addend    = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
  assign product   = acc + addend;
  assign last_step = step && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (sig) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= ina;
      mplier <= inb;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/mult8_sched.sv
// mult8_sched: round-robin arbiter sharing one shift-add multiplier between two requesters.
// Rev 1.0
`default_nettype none
module mult8_sched
  import mult8_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               sig,
  input  logic               req_a_valid,
  output logic               req_a_ready,
  input  logic [WIDTH-1:0]   req_a_ina,
  input  logic [WIDTH-1:0]   req_a_inb,
  input  logic               req_b_valid,
  output logic               req_b_ready,
  input  logic [WIDTH-1:0]   req_b_ina,
  input  logic [WIDTH-1:0]   req_b_inb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_out,
  output logic               rsp_id
);
  state_t             state, state_next;
  logic               prio;
  logic               grant_a, grant_b;
  logic               load, step, last_step;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] product;

  assign grant_a = req_a_valid && (!req_b_valid || prio == ID_A);
  assign grant_b = req_b_valid && (!req_a_valid || prio == ID_B);
  assign op_a    = grant_b ? req_b_ina : req_a_ina;
  assign op_b    = grant_b ? req_b_inb : req_a_inb;

  always_comb begin
    state_next  = state;
    req_a_ready = 1'b0;
    req_b_ready = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state)
      IDLE: begin
        if (!sig) begin
          req_a_ready = grant_a;
          req_b_ready = grant_b;
          if (grant_a || grant_b) begin
            load       = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sig) begin
      state   <= IDLE;
      prio    <= ID_A;
      rsp_id  <= ID_A;
      rsp_out <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        prio   <= ~prio;
        rsp_id <= grant_b ? ID_B : ID_A;
      end
      // capture the final sum so the output holds steady through backpressure
      if (last_step) rsp_out <= product;
    end
  end

  assign rsp_valid = (state == DONE);

  shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .sig       (sig),
    .load      (load),
    .step      (step),
    .ina       (op_a),
    .inb       (op_b),
    .last_step (last_step),
    .product   (product)
  );
endmodule
`default_nettype wire

// File: tb/tb_mult8_sched.sv
// tb_mult8_sched: randomized and directed scoreboard bench for mult8_sched.
// Rev 1.0
`default_nettype none
module tb_mult8_sched;
  logic       clk = 1'b0;
  logic       sig = 1'b1;
  logic       req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic       req_a_ready, req_b_ready;
  logic [7:0] req_a_ina = '0, req_a_inb = '0, req_b_ina = '0, req_b_inb = '0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [15:0] rsp_out;

  mult8_sched #(.WIDTH(8)) dut (
    .clk(clk), .sig(sig),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready),
    .req_a_ina(req_a_ina), .req_a_inb(req_a_inb),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready),
    .req_b_ina(req_b_ina), .req_b_inb(req_b_inb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  typedef struct { logic id; logic [15:0] p; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0;
  bit busy = 0, ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one job in flight, result due 8 cycles after the accept edge,
  // ties go to the pointer, which flips on every accept.
  always @(negedge clk) begin
    bit era, erb, erv;
    exp_t e;
    if (sig) begin
      chk(!req_a_ready && !req_b_ready, "ready_in_reset", {req_a_ready, req_b_ready}, 0);
      q.delete();
      busy = 0;
      ptr  = 0;
    end else begin
      era = !busy && req_a_valid && (!req_b_valid || ptr == 1'b0);
      erb = !busy && req_b_valid && (!req_a_valid || ptr == 1'b1);
      erv = busy && (cyc - acc_cyc >= 9);
      chk(req_a_ready == era, "req_a_ready", req_a_ready, era);
      chk(req_b_ready == erb, "req_b_ready", req_b_ready, erb);
      chk(rsp_valid == erv, "rsp_valid", rsp_valid, erv);
      if (rsp_valid && erv) begin
        if (q.size() == 0) begin
          chk(0, "rsp_unexpected", rsp_out, -1);
        end else begin
          chk(rsp_out == q[0].p, "rsp_out", rsp_out, q[0].p);
          chk(rsp_id == q[0].id, "rsp_id", rsp_id, q[0].id);
          if (rsp_ready) begin
            void'(q.pop_front());
            busy = 0;
          end
        end
      end
      if (req_a_valid && req_a_ready) begin
        e.id = 1'b0; e.p = {8'b0, req_a_ina} * {8'b0, req_a_inb};
        q.push_back(e); busy = 1; acc_cyc = cyc; ptr = ~ptr;
      end else if (req_b_valid && req_b_ready) begin
        e.id = 1'b1; e.p = {8'b0, req_b_ina} * {8'b0, req_b_inb};
        q.push_back(e); busy = 1; acc_cyc = cyc; ptr = ~ptr;
      end
    end
  end

  task automatic send(input bit id, input logic [7:0] x, input logic [7:0] y);
    int  n = 0;
    bit  done = 0;
    if (id == 1'b0) begin req_a_ina = x; req_a_inb = y; req_a_valid = 1'b1; end
    else            begin req_b_ina = x; req_b_inb = y; req_b_valid = 1'b1; end
    while (!done && n < 200) begin
      @(negedge clk);
      done = id ? (req_b_valid && req_b_ready) : (req_a_valid && req_a_ready);
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk(0, "send_timeout", n, 200);
    if (id == 1'b0) req_a_valid = 1'b0; else req_b_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    if (busy || q.size() != 0) chk(0, "idle_timeout", n, 100);
  endtask

  task automatic pulse_reset(input int cycles);
    sig = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 sig = 1'b0;
  endtask

  initial begin
    int n;
    pulse_reset(3);
    @(negedge clk);
    chk(rsp_out == 16'd0, "reset_rsp_out", rsp_out, 0);
    chk(rsp_id == 1'b0, "reset_rsp_id", rsp_id, 0);
    chk(rsp_valid == 1'b0, "reset_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;

    send(0, 8'd13, 8'd11);
    wait_idle();

    pulse_reset(1);
    fork
      begin send(0, 8'd3, 8'd5);  send(0, 8'd4, 8'd6); end
      begin send(1, 8'd7, 8'd9);  send(1, 8'd10, 8'd11); end
    join
    wait_idle();

    send(0, 8'd255, 8'd255); wait_idle();
    send(1, 8'd0, 8'd200);   wait_idle();
    send(0, 8'd1, 8'd255);   wait_idle();
    send(1, 8'd128, 8'd2);   wait_idle();

    // backpressure: hold DONE for 5 cycles while B waits
    rsp_ready = 1'b0;
    send(0, 8'd200, 8'd3);
    fork
      send(1, 8'd5, 8'd5);
      begin
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) chk(0, "bp_timeout", n, 50);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // reset in the 4th RUN cycle discards A's 9*9
    send(0, 8'd9, 8'd9);
    repeat (3) @(posedge clk);
    #1 pulse_reset(1);
    fork
      send(0, 8'd6, 8'd7);
      send(1, 8'd8, 8'd3);
    join
    wait_idle();

    send(1, 8'd2, 8'd2);
    send(1, 8'd4, 8'd4);
    send(1, 8'd6, 8'd6);
    send(1, 8'd8, 8'd8);
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      req_a_valid = 1'($urandom_range(0, 1));
      req_b_valid = 1'($urandom_range(0, 1));
      req_a_ina = 8'($urandom); req_a_inb = 8'($urandom);
      req_b_ina = 8'($urandom); req_b_inb = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    rsp_ready   = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
